dir_ctrl: RTL and testbench
===========================

# dir_ctrl

Consumer of the single-cycle key pulses from the four per-button edge detectors. It turns them into the snake's heading, which the movement logic samples. Accepted turns are buffered in a small queue and applied one per game step, so that two quick presses between steps both take effect. Turns that are illegal (same heading or 180° reversal) are rejected at entry.

## Interface
Parameters:
- DEPTH, 2: turn queue depth (entries); legal range 1..4.
- INIT_DIR, 2'd3 (RIGHT): heading after reset or clear.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- key_up_v  input  1  one-cycle press pulse, UP button.
- key_down_v  input  1  one-cycle press pulse, DOWN button.
- key_left_v  input  1  one-cycle press pulse, LEFT button.
- key_right_v  input  1  one-cycle press pulse, RIGHT button.
- step  input  1  one-cycle game-tick pulse; head advances on this tick.
- clear  input  1  synchronous game restart.
- dir  output  2  current heading: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- turn  output  1  one-cycle pulse; dir changed this cycle.
- drop  output  1  one-cycle pulse; a legal key was lost because the queue was full.
- pending  output  3  number of queued turns (0..DEPTH).

## Operation
- Encoding: opposite(d) = d ^ 2'b01.
- Key select: when several pulses arrive in one cycle, priority is UP > DOWN > LEFT > RIGHT. Only the winner is evaluated; the others are discarded silently.
- Reference heading ref: the newest queue entry if the queue is non-empty, else dir. Both values are taken before any pop in the same cycle.
- Legality: the key k is rejected silently if k == ref or k == opposite(ref).
- Enqueue: a legal k is written at the tail if a slot is free after this cycle's pop.
  - Otherwise drop = 1 and k is lost.
- step with a non-empty queue: dir <= head, the head is popped, turn = 1.
- step with an empty queue: dir is held, turn = 0.
- A key enqueued in the same cycle as step is never applied by that step; it is applied at the next step at the earliest.
- clear overrides everything in its cycle:
  - dir <= INIT_DIR and the queue is emptied.
  - turn = 0 and drop = 0.
  - Keys and step in that cycle are ignored.
- The queue is a circular buffer. Read and write pointers wrap modulo DEPTH. pending is an explicit counter, not a pointer difference.

## Timing
- Reset values: dir = INIT_DIR, turn = 0, drop = 0, pending = 0; queue contents are don't-care.
- All outputs are registered.
- Key to pending: a key pulse in cycle n raises pending in cycle n+1.
- Step to heading: a step in cycle n updates dir in cycle n+1, with turn high for exactly cycle n+1.
- drop is high in cycle n+1 for a key lost in cycle n.
- Full queue plus step plus legal key in the same cycle: the pop frees a slot, the key is accepted, pending stays at DEPTH, drop = 0.
- Empty queue plus step plus key in the same cycle: ref = dir, the key is queued, dir is unchanged.
- An asynchronous reset in the middle of a sequence discards all queued turns immediately.
- No combinational path exists from any input to any output.

## Structure
- Shared package snake_pkg:
  - direction typedef and constants DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT;
  - function opposite();
  - default INIT_DIR.
  - The movement and collision blocks import the same package.
- Sub-module dir_fifo: a DEPTH-entry, 2-bit-wide circular queue with push, pop, head, tail_last, count, full and empty. It supports simultaneous push and pop when full.
- Key priority selection and the legality check stay inline in dir_ctrl.

## Test plan
- Reset, then ten steps with no keys -> dir = 3 throughout; turn and pending stay 0.
- dir = RIGHT, key_left_v pulse, then key_right_v pulse -> both rejected; pending = 0, no drop.
- dir = RIGHT, key_up_v then key_left_v in separate cycles before a step -> pending = 2. Step 1 gives dir = 0 with a turn pulse; step 2 gives dir = 2.
- DEPTH = 2 with queue [UP, LEFT]:
  - key_down_v -> drop = 1 for one cycle, pending stays 2.
  - Repeat with step asserted in the same cycle -> accepted, pending = 2, head = LEFT.
- key_up_v and key_left_v in the same cycle with dir = RIGHT -> only UP is queued; pending = 1.
- clear asserted with pending = 2 and step high in the same cycle -> next cycle dir = INIT_DIR, pending = 0, turn = 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game types: heading encoding, opposite-direction helper and default heading.
// Imported by direction control, movement and collision logic.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    localparam dir_t INIT_DIR_DEFAULT = DIR_RIGHT;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/dir_ctrl_if.sv
// Key/step/clear inputs and heading outputs of the direction controller.
// The game side drives through master; dir_ctrl connects through slave.
interface dir_ctrl_if;
    import snake_pkg::*;

    logic       key_up_v;
    logic       key_down_v;
    logic       key_left_v;
    logic       key_right_v;
    logic       step;
    logic       clear;
    dir_t       dir;
    logic       turn;
    logic       drop;
    logic [2:0] pending;

    modport master (
        output key_up_v, key_down_v, key_left_v, key_right_v, step, clear,
        input  dir, turn, drop, pending
    );

    modport slave (
        input  key_up_v, key_down_v, key_left_v, key_right_v, step, clear,
        output dir, turn, drop, pending
    );

endinterface

// File: rtl/dir_fifo.sv
// Circular queue of pending headings with explicit occupancy counter.
// Push and pop may coincide even when full; the caller never pushes a full queue without a pop.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_push,
    input  logic       i_pop,
    input  dir_t       i_data,
    output dir_t       o_head,
    output dir_t       o_tail_last,
    output logic [2:0] o_count,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    dir_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [2:0]       r_count;
    logic [PTR_W-1:0] w_last_ptr;
    logic [2:0]       w_count_d;

    assign w_last_ptr  = (r_wr_ptr == '0) ? PTR_LAST : r_wr_ptr - 1'b1;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_tail_last = r_mem[w_last_ptr];
    assign o_count     = r_count;
    assign o_full      = (r_count == 3'(DEPTH));
    assign o_empty     = (r_count == 3'd0);

    always_comb begin
        w_count_d = r_count;
        if (i_push && !i_pop) begin
            w_count_d = r_count + 3'd1;
        end else if (i_pop && !i_push) begin
            w_count_d = r_count - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 3'd0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 3'd0;
        end else begin
            if (i_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count <= w_count_d;
        end
    end

    // Storage needs no reset: contents are only read while the counter says they are valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/dir_ctrl.sv
// Snake heading controller: selects one key per cycle, rejects same/reverse turns,
// queues accepted turns and applies one per game step.
module dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter dir_t        INIT_DIR = INIT_DIR_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    dir_ctrl_if.slave bus
);

    logic       w_key_v;
    dir_t       w_key;
    dir_t       w_ref;
    logic       w_legal;
    logic       w_pop;
    logic       w_push;
    logic       w_space;
    logic       w_drop;
    dir_t       w_head;
    dir_t       w_tail_last;
    logic [2:0] w_count;
    logic       w_full;
    logic       w_empty;

    dir_t       r_dir;
    logic       r_turn;
    logic       r_drop;

    always_comb begin
        w_key_v = 1'b1;
        w_key   = DIR_UP;
        if (bus.key_up_v)         w_key = DIR_UP;
        else if (bus.key_down_v)  w_key = DIR_DOWN;
        else if (bus.key_left_v)  w_key = DIR_LEFT;
        else if (bus.key_right_v) w_key = DIR_RIGHT;
        else                      w_key_v = 1'b0;
    end

    // Legality is judged against the last heading the snake will take, not the current one.
    assign w_ref   = w_empty ? r_dir : w_tail_last;
    assign w_legal = w_key_v && (w_key != w_ref) && (w_key != opposite(w_ref));
    assign w_pop   = bus.step && !w_empty && !bus.clear;
    assign w_space = !w_full || w_pop;
    assign w_push  = w_legal && w_space && !bus.clear;
    assign w_drop  = w_legal && !w_space && !bus.clear;

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (bus.clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (w_key),
        .o_head      (w_head),
        .o_tail_last (w_tail_last),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir  <= INIT_DIR;
            r_turn <= 1'b0;
            r_drop <= 1'b0;
        end else if (bus.clear) begin
            r_dir  <= INIT_DIR;
            r_turn <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (w_pop) r_dir <= w_head;
            r_turn <= w_pop;
            r_drop <= w_drop;
        end
    end

    assign bus.dir     = r_dir;
    assign bus.turn    = r_turn;
    assign bus.drop    = r_drop;
    assign bus.pending = w_count;

endmodule

// File: tb/tb_dir_ctrl.sv
// Randomised self-checking bench for dir_ctrl against a queue-based heading model,
// preceded by directed scenarios with hand-computed expectations.
module tb_dir_ctrl;
    import snake_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [1:0] INIT = 2'd3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    dir_ctrl_if bus ();

    dir_ctrl #(
        .DEPTH    (DEPTH),
        .INIT_DIR (INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    logic       m_turn;
    logic       m_drop;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dir  = INIT;
        m_turn = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_step(input logic u, input logic d, input logic l, input logic r,
                              input logic s, input logic c);
        logic [1:0] k;
        logic [1:0] rf;
        logic       kv;
        m_turn = 1'b0;
        m_drop = 1'b0;
        if (c) begin
            m_q.delete();
            m_dir = INIT;
            return;
        end
        kv = u | d | l | r;
        k  = u ? 2'd0 : d ? 2'd1 : l ? 2'd2 : 2'd3;
        rf = (m_q.size() > 0) ? m_q[$] : m_dir;
        if (s && m_q.size() > 0) begin
            m_dir  = m_q.pop_front();
            m_turn = 1'b1;
        end
        if (kv && k != rf && k != (rf ^ 2'b01)) begin
            if (m_q.size() < DEPTH) m_q.push_back(k);
            else m_drop = 1'b1;
        end
    endtask

    task automatic compare_model();
        check("dir", int'(bus.dir), int'(m_dir));
        check("turn", int'(bus.turn), int'(m_turn));
        check("drop", int'(bus.drop), int'(m_drop));
        check("pending", int'(bus.pending), m_q.size());
    endtask

    // One clock: drive, advance the model, sample 1 ns after the edge and compare.
    task automatic drive(input logic u, input logic d, input logic l, input logic r,
                         input logic s, input logic c);
        bus.key_up_v    = u;
        bus.key_down_v  = d;
        bus.key_left_v  = l;
        bus.key_right_v = r;
        bus.step        = s;
        bus.clear       = c;
        model_step(u, d, l, r, s, c);
        @(posedge clk);
        #1;
        bus.key_up_v    = 1'b0;
        bus.key_down_v  = 1'b0;
        bus.key_left_v  = 1'b0;
        bus.key_right_v = 1'b0;
        bus.step        = 1'b0;
        bus.clear       = 1'b0;
        compare_model();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.key_up_v    = 1'b0;
        bus.key_down_v  = 1'b0;
        bus.key_left_v  = 1'b0;
        bus.key_right_v = 1'b0;
        bus.step        = 1'b0;
        bus.clear       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dir", int'(bus.dir), 3);
        check("rst_turn", int'(bus.turn), 0);
        check("rst_drop", int'(bus.drop), 0);
        check("rst_pending", int'(bus.pending), 0);
        rst_n = 1'b1;

        // Ten idle steps: heading holds.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            check("idle_dir", int'(bus.dir), 3);
            check("idle_turn", int'(bus.turn), 0);
        end

        // Same-heading and reversal rejected.
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("rej_pending", int'(bus.pending), 0);
        check("rej_drop", int'(bus.drop), 0);

        // Two buffered turns applied on two steps.
        drive(1, 0, 0, 0, 0, 0);
        check("q1_pending", int'(bus.pending), 1);
        drive(0, 0, 1, 0, 0, 0);
        check("q2_pending", int'(bus.pending), 2);
        drive(0, 0, 0, 0, 1, 0);
        check("s1_dir", int'(bus.dir), 0);
        check("s1_turn", int'(bus.turn), 1);
        drive(0, 0, 0, 0, 1, 0);
        check("s2_dir", int'(bus.dir), 2);
        drive(0, 0, 0, 0, 0, 0);
        check("s2_turn_end", int'(bus.turn), 0);

        // Full queue [UP, LEFT] from RIGHT.
        drive(0, 0, 0, 0, 0, 1);
        check("clr_dir", int'(bus.dir), 3);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("full_drop", int'(bus.drop), 1);
        check("full_pending", int'(bus.pending), 2);
        drive(0, 0, 0, 0, 0, 0);
        check("drop_pulse", int'(bus.drop), 0);
        drive(0, 1, 0, 0, 1, 0);
        check("fs_drop", int'(bus.drop), 0);
        check("fs_pending", int'(bus.pending), 2);
        check("fs_dir", int'(bus.dir), 0);
        drive(0, 0, 0, 0, 1, 0);
        check("fs_head", int'(bus.dir), 2);
        drive(0, 0, 0, 0, 1, 0);
        check("fs_tail", int'(bus.dir), 1);

        // Simultaneous keys: priority selects UP only.
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 0);
        check("prio_pending", int'(bus.pending), 1);
        drive(0, 0, 1, 0, 0, 0);
        check("prio_pending2", int'(bus.pending), 2);

        // Clear beats step.
        drive(0, 0, 0, 0, 1, 1);
        check("clrs_dir", int'(bus.dir), 3);
        check("clrs_pending", int'(bus.pending), 0);
        check("clrs_turn", int'(bus.turn), 0);

        // Empty queue, step and key together: key queued, dir held.
        drive(0, 1, 0, 0, 1, 0);
        check("es_dir", int'(bus.dir), 3);
        check("es_pending", int'(bus.pending), 1);

        // Asynchronous reset between edges flushes the queue at once.
        drive(0, 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pending", int'(bus.pending), 0);
        check("arst_dir", int'(bus.dir), 3);
        #2;
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
